// File: rtl/vad_decision.sv
// vad_decision: frame-level speech/non-speech decision with onset/hangover
// smoothing. Raw decision is (score_sp - score_ns) > 0, evaluated without
// overflow. The smoothed flag is registered and presented one cycle after the
// frame strobe.
// Optional feature: define VAD_DEC_STATS_EN to add the saturating
// speech_frames counter and its output port.
module vad_decision #(
  parameter int SCORE_W = 8,
  parameter int ONSET_N = 3,
  parameter int HANG_N  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_sp,
  input  logic [SCORE_W-1:0] score_ns,
  output logic               vad_valid,
  output logic               vad_out,
`ifdef VAD_DEC_STATS_EN
  output logic               vad_edge,
  output logic [CNT_W-1:0]   speech_frames
`else
  output logic               vad_edge
`endif
);

  typedef enum logic [1:0] {
    SIL    = 2'd0,
    SPEECH = 2'd1,
    HANG   = 2'd2
  } state_e;

  localparam logic [7:0] ONSET_L = 8'(ONSET_N);
  localparam logic [7:0] HANG_L  = 8'(HANG_N);

  state_e     state_q, state_d;
  logic [7:0] onset_cnt_q, onset_cnt_d;
  logic [7:0] hang_cnt_q, hang_cnt_d;
  logic       vad_out_q, vad_out_d;
  logic       vad_valid_q, vad_valid_d;
  logic       vad_edge_q, vad_edge_d;

  logic signed [SCORE_W:0] diff;
  logic                    raw;

  // Sign-extend both scores by one bit so the difference can never wrap.
  always_comb begin
    diff = $signed({score_sp[SCORE_W-1], score_sp}) -
           $signed({score_ns[SCORE_W-1], score_ns});
    raw  = !diff[SCORE_W] && (diff != '0);
  end

  // Next-state logic: the FSM advances only on strobed frames.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    onset_cnt_d = onset_cnt_q;
    hang_cnt_d  = hang_cnt_q;
    if (score_valid) begin
      case (state_q)
        SIL: begin
          if (raw) begin
            if (onset_cnt_q + 8'd1 >= ONSET_L) begin
              state_d     = SPEECH;
              onset_cnt_d = 8'd0;
            end else begin
              onset_cnt_d = onset_cnt_q + 8'd1;
            end
          end else begin
            onset_cnt_d = 8'd0;
          end
        end
        SPEECH: begin
          if (!raw) begin
            if (HANG_L <= 8'd1) begin
              state_d    = SIL;
              hang_cnt_d = 8'd0;
            end else begin
              state_d    = HANG;
              hang_cnt_d = 8'd1;
            end
          end
        end
        HANG: begin
          if (raw) begin
            state_d    = SPEECH;
            hang_cnt_d = 8'd0;
          end else if (hang_cnt_q + 8'd1 >= HANG_L) begin
            state_d    = SIL;
            hang_cnt_d = 8'd0;
          end else begin
            hang_cnt_d = hang_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d     = SIL;
          onset_cnt_d = 8'd0;
          hang_cnt_d  = 8'd0;
        end
      endcase
    end
  end

  // Output strobes and the held flag derived from the post-transition state.
  always_comb begin
    vad_valid_d = score_valid;
    vad_out_d   = vad_out_q;
    vad_edge_d  = 1'b0;
    if (score_valid) begin
      vad_out_d  = (state_d != SIL);
      vad_edge_d = vad_out_d ^ vad_out_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SIL;
      onset_cnt_q <= 8'd0;
      hang_cnt_q  <= 8'd0;
      vad_out_q   <= 1'b0;
      vad_valid_q <= 1'b0;
      vad_edge_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q     <= state_d;
      onset_cnt_q <= onset_cnt_d;
      hang_cnt_q  <= hang_cnt_d;
      vad_out_q   <= vad_out_d;
      vad_valid_q <= vad_valid_d;
      vad_edge_q  <= vad_edge_d;
    end
  end

  assign vad_valid = vad_valid_q;
  assign vad_out   = vad_out_q;
  assign vad_edge  = vad_edge_q;

`ifdef VAD_DEC_STATS_EN
  logic [CNT_W-1:0] speech_frames_q, speech_frames_d;

  // Saturating count of processed frames that end in speech.
  always_comb begin
    speech_frames_d = speech_frames_q;
    if (score_valid && vad_out_d && (speech_frames_q != '1))
      speech_frames_d = speech_frames_q + 1'b1;
  end

  // Statistics counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) speech_frames_q <= '0;
    else        speech_frames_q <= speech_frames_d;
  end

  assign speech_frames = speech_frames_q;
`endif

endmodule

// File: tb/tb_vad_decision.sv
// Directed bench for vad_decision (ONSET_N=3, HANG_N=8, SCORE_W=8).
// Inputs change on the falling edge; outputs are sampled on the next falling
// edge, i.e. after the rising edge that consumed the frame.
module tb_vad_decision;

  localparam int SCORE_W = 8;
`ifdef VAD_DEC_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               score_valid = 1'b0;
  logic [SCORE_W-1:0] score_sp = '0;
  logic [SCORE_W-1:0] score_ns = '0;
  logic               vad_valid;
  logic               vad_out;
  logic               vad_edge;
`ifdef VAD_DEC_STATS_EN
  logic [CNT_W-1:0]   speech_frames;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vad_decision #(
    .SCORE_W(SCORE_W),
    .ONSET_N(3),
    .HANG_N (8),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .score_valid  (score_valid),
    .score_sp     (score_sp),
    .score_ns     (score_ns),
    .vad_valid    (vad_valid),
    .vad_out      (vad_out),
`ifdef VAD_DEC_STATS_EN
    .vad_edge     (vad_edge),
    .speech_frames(speech_frames)
`else
    .vad_edge     (vad_edge)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic o, input logic e);
    check({tag, ".valid"}, {31'd0, vad_valid}, {31'd0, v});
    check({tag, ".out"},   {31'd0, vad_out},   {31'd0, o});
    check({tag, ".edge"},  {31'd0, vad_edge},  {31'd0, e});
  endtask

  // Present one cycle of input, then wait to the falling edge where its result shows.
  task automatic step(input logic v, input logic signed [7:0] sp, input logic signed [7:0] ns);
    score_valid = v;
    score_sp    = sp;
    score_ns    = ns;
    @(negedge clk);
  endtask

  initial begin
    // Reset held; a strobed frame during reset must be discarded.
    @(negedge clk);
    step(1'b1, 8'sd20, -8'sd5);
    chk_out("rst_hold0", 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'sd20, -8'sd5);
    chk_out("rst_hold1", 1'b0, 1'b0, 1'b0);
`ifdef VAD_DEC_STATS_EN
    check("rst_sf", {28'd0, speech_frames}, 32'd0);
`endif
    score_valid = 1'b0;
    rst_n = 1'b1;

    // Idle: nothing may pulse for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'sd20, -8'sd5);
      check("idle.valid", {31'd0, vad_valid}, 32'd0);
      check("idle.out",   {31'd0, vad_out},   32'd0);
    end

    // Onset: three back-to-back speech frames.
    step(1'b1, 8'sd20, -8'sd5);  chk_out("onset1", 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'sd20, -8'sd5);  chk_out("onset2", 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'sd20, -8'sd5);  chk_out("onset3", 1'b1, 1'b1, 1'b1);
    step(1'b0, 8'sd0, 8'sd0);    chk_out("onset_hold", 1'b0, 1'b1, 1'b0);

    // Hangover: 7 non-speech, 1 speech, 8 non-speech.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, -8'sd5, 8'sd20); chk_out("hang_a", 1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 8'sd20, -8'sd5);   chk_out("hang_sp", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, -8'sd5, 8'sd20); chk_out("hang_b", 1'b1, 1'b1, 1'b0);
    end
    step(1'b1, -8'sd5, 8'sd20);   chk_out("hang_end", 1'b1, 1'b0, 1'b1);

    // Onset interrupted by a tie, which restarts the onset count.
    step(1'b1, 8'sd20, -8'sd5);   chk_out("intr1", 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'sd20, -8'sd5);   chk_out("intr2", 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'sd7, 8'sd7);     chk_out("intr_tie", 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'sd20, -8'sd5);   chk_out("intr4", 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'sd20, -8'sd5);   chk_out("intr5", 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'sd20, -8'sd5);   chk_out("intr6", 1'b1, 1'b1, 1'b1);

    // Extreme scores, probed in HANG at count 7 where raw decides the outcome.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, -8'sd5, 8'sd20); chk_out("ovf_a", 1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 8'sd127, -8'sd128); chk_out("ovf_pos", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, -8'sd5, 8'sd20); chk_out("ovf_b", 1'b1, 1'b1, 1'b0);
    end
    step(1'b1, -8'sd128, 8'sd127); chk_out("ovf_neg", 1'b1, 1'b0, 1'b1);

    // Reach SPEECH again, then reset mid-frame: clears asynchronously.
    for (int i = 0; i < 3; i++) step(1'b1, 8'sd20, -8'sd5);
    check("pre_rst.out", {31'd0, vad_out}, 32'd1);
    score_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("rst_discard", 1'b0, 1'b0, 1'b0);
`ifdef VAD_DEC_STATS_EN
    check("rst_mid_sf", {28'd0, speech_frames}, 32'd0);
`endif
    score_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 20 speech frames: frames 3..20 are speech (18), counter saturates at 15.
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 8'sd20, -8'sd5);
`ifdef VAD_DEC_STATS_EN
      if (k == 3)  check("sf_k3",  {28'd0, speech_frames}, 32'd1);
      if (k == 17) check("sf_k17", {28'd0, speech_frames}, 32'd15);
      if (k == 20) check("sf_sat", {28'd0, speech_frames}, 32'd15);
`endif
    end
    check("run20.out", {31'd0, vad_out}, 32'd1);

    // Mid-stream reset clears outputs and statistics.
    #2 rst_n = 1'b0;
    #1 check("rst2.out", {31'd0, vad_out}, 32'd0);
`ifdef VAD_DEC_STATS_EN
    check("rst2.sf", {28'd0, speech_frames}, 32'd0);
`endif
    score_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'sd0, 8'sd0);
    chk_out("post_rst2", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
